// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: single BCD digit up/down counter with prescaler, load, tick and carry pulses.
// Define BCD_CNT_CASCADE_EN to drop the prescaler and step from the cin input instead.
module bcd_digit_counter #(
  parameter int DIV       = 50_000_000,
  parameter int MAX_DIGIT = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
`ifdef BCD_CNT_CASCADE_EN
  input  logic       cin,
`endif
  output logic       F,
  output logic       E,
  output logic       D,
  output logic       C,
  output logic       B,
  output logic       A,
  output logic       tick,
  output logic       carry
);
  localparam logic [3:0] MAX = 4'(MAX_DIGIT);
  logic [3:0] dig_q, dig_d, stepped;
  logic       tick_q, tick_d, carry_q, carry_d, step, wrap;
`ifdef BCD_CNT_CASCADE_EN
  assign step = en & cin;
`else
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  logic [PW-1:0] pre_q, pre_d;
  assign step = en && (pre_q == PMAX);
  // load restarts the period so the next step is a full DIV clocks away
  always_comb pre_d = load ? '0 : !en ? pre_q : step ? '0 : pre_q + PW'(1);
  always_ff @(posedge clk) pre_q <= rst ? '0 : pre_d;
`endif
  assign wrap    = up ? (dig_q == MAX) : (dig_q == 4'd0);
  assign stepped = wrap ? (up ? 4'd0 : MAX) : (up ? dig_q + 4'd1 : dig_q - 4'd1);
  always_comb begin
    dig_d   = load ? ((load_val > MAX) ? MAX : load_val) : step ? stepped : dig_q;
    tick_d  = !load && step;
    carry_d = !load && step && wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q   <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      dig_q   <= dig_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end
  assign {F, E, D, C, B, A} = {2'b00, dig_q};
  assign tick  = tick_q;
  assign carry = carry_q;
endmodule

// File: tb/tb_bcd_digit_counter.sv
// tb_bcd_digit_counter: directed scoreboard bench for bcd_digit_counter (DIV=4, MAX_DIGIT=9).
module tb_bcd_digit_counter;
  typedef struct packed {
    logic [5:0]  code;
    logic        carry;
    int unsigned cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst, en, up, load;
  logic [3:0] load_val;
`ifdef BCD_CNT_CASCADE_EN
  logic cin = 1'b0;
`endif
  logic F, E, D, C, B, A, tick, carry;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  int unsigned t;
  exp_t q[$];

  bcd_digit_counter #(.DIV(4), .MAX_DIGIT(9)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
`ifdef BCD_CNT_CASCADE_EN
    .cin(cin),
`endif
    .F(F), .E(E), .D(D), .C(C), .B(B), .A(A), .tick(tick), .carry(carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic c, input int unsigned at);
    q.push_back('{code: {2'b00, d}, carry: c, cyc: at});
  endtask

  // Monitor: every tick must match the oldest expected step, including its cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst && carry && !tick) chk("carry_without_tick", 1, 0);
    if (!rst && tick) begin
      if (q.size() == 0) chk("unexpected_tick", 1, 0);
      else begin
        e = q.pop_front();
        chk("step_code", int'({F, E, D, C, B, A}), int'(e.code));
        chk("step_carry", int'(carry), int'(e.carry));
        chk("step_cycle", int'(cyc), int'(e.cyc));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd5;
    repeat (2) @(negedge clk);
    chk("reset_code", int'({F, E, D, C, B, A}), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_carry", int'(carry), 0);
    rst = 1'b0; load = 1'b0;
`ifdef BCD_CNT_CASCADE_EN
    en = 1'b1; load = 1'b1; load_val = 4'd8;
    @(negedge clk);
    load = 1'b0;
    chk("casc_load", int'({F, E, D, C, B, A}), 8);
    t = cyc;
    push(4'd9, 1'b0, t + 1);
    push(4'd0, 1'b1, t + 2);
    push(4'd1, 1'b0, t + 3);
    cin = 1'b1;
    repeat (3) @(negedge clk);
    cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("casc_hold", int'({F, E, D, C, B, A}), 1);
`else
    // count up for 40 clocks: 1..9 then 0 with carry, a step every 4 clocks
    t = cyc;
    for (int n = 1; n <= 10; n++) push(4'(n % 10), n == 10, t + 4 * n);
    repeat (40) @(negedge clk);
    chk("up_wrap_digit", int'({F, E, D, C, B, A}), 0);
    // count down from 0: 9 with carry, then 8 without
    up = 1'b0;
    t = cyc;
    push(4'd9, 1'b1, t + 4);
    push(4'd8, 1'b0, t + 8);
    repeat (8) @(negedge clk);
    // load 13 clamps to 9; next (up) step exactly 4 clocks after the load
    load = 1'b1; load_val = 4'd13; up = 1'b1;
    t = cyc;
    @(negedge clk);
    load = 1'b0;
    chk("load_clamp", int'({F, E, D, C, B, A}), 9);
    chk("load_tick", int'(tick), 0);
    push(4'd0, 1'b1, t + 5);
    repeat (4) @(negedge clk);
    // pause after 2 prescaler counts; step arrives 2 clocks after resuming
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_digit", int'({F, E, D, C, B, A}), 0);
    chk("hold_tick", int'(tick), 0);
    en = 1'b1;
    t = cyc;
    push(4'd1, 1'b0, t + 2);
    repeat (2) @(negedge clk);
    // load on the cycle a step would fire wins and restarts the period
    repeat (3) @(negedge clk);
    load = 1'b1; load_val = 4'd3;
    t = cyc;
    @(negedge clk);
    load = 1'b0;
    chk("load_vs_step_digit", int'({F, E, D, C, B, A}), 3);
    chk("load_vs_step_tick", int'(tick), 0);
    push(4'd4, 1'b0, t + 5);
    repeat (5) @(negedge clk);
    // load works with en low
    en = 1'b0; load = 1'b1; load_val = 4'd7;
    @(negedge clk);
    load = 1'b0;
    chk("load_disabled", int'({F, E, D, C, B, A}), 7);
    repeat (6) @(negedge clk);
    chk("load_disabled_hold", int'({F, E, D, C, B, A}), 7);
    // mid-run reset
    en = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rerst_code", int'({F, E, D, C, B, A}), 0);
    chk("rerst_tick", int'(tick), 0);
    rst = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
